// File: rtl/wide_add_pkg.sv
// Shared types and constants for the multi-limb add/subtract sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package wide_add_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_LIMBS = 4;

    // Per-bit carry status pair {propagate, not_kill}.
    localparam logic [1:0] KGP_KILL = 2'b00;
    localparam logic [1:0] KGP_GEN  = 2'b01;
    localparam logic [1:0] KGP_PROP = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/kgp_adder_cin.sv
// WIDTH-bit recursive-doubling (kill/generate/propagate) adder with carry-in.
// Latency: purely combinational.
// Backpressure: none.
// Ports: a, b (addends), cin (carry-in), sum, cout (carry out of MSB),
//        cmsb (carry into the MSB, used for signed overflow).
module kgp_adder_cin
    import wide_add_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             cmsb
);

    logic [WIDTH:0] c;

    always_comb begin
        logic [WIDTH-1:0][1:0] lvl;
        logic [WIDTH-1:0][1:0] nxt;
        lvl = '0;
        nxt = '0;
        c   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            lvl[i] = {a[i] ^ b[i], a[i] | b[i]};
        end
        // Carry-in folded into bit 0: its status is then always kill or
        // generate, so every prefix resolves to a definite carry.
        lvl[0] = ((a[0] & b[0]) | (a[0] & cin) | (b[0] & cin)) ? KGP_GEN : KGP_KILL;
        // Doubling span each level: a propagating span takes the status of
        // the span below it.
        for (int d = 1; d < WIDTH; d = d * 2) begin
            nxt = lvl;
            for (int i = d; i < WIDTH; i++) begin
                nxt[i] = (lvl[i] == KGP_PROP) ? lvl[i-d] : lvl[i];
            end
            lvl = nxt;
        end
        c[0] = cin;
        for (int i = 0; i < WIDTH; i++) begin
            c[i+1] = (lvl[i] == KGP_GEN);
        end
    end

    assign sum  = a ^ b ^ c[WIDTH-1:0];
    assign cout = c[WIDTH];
    assign cmsb = c[WIDTH-1];

endmodule

// File: rtl/wide_add_sequencer.sv
// Wide add/subtract: one limb per cycle through a single kgp adder, carry chained in a register.
// Latency: out_valid rises LIMBS edges after the accepting edge; accepts spaced >= LIMBS+2 cycles.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready.
// Ports: clk, rst_n; in_valid/in_ready/in_a/in_b/in_sub request side;
//        out_valid/out_ready/out_sum/out_cout/out_ovf result side; busy = RUN or DONE.
module wide_add_sequencer
    import wide_add_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LIMBS = DEF_LIMBS
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH*LIMBS-1:0] in_a,
    input  logic [WIDTH*LIMBS-1:0] in_b,
    input  logic                   in_sub,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH*LIMBS-1:0] out_sum,
    output logic                   out_cout,
    output logic                   out_ovf,
    output logic                   busy
);

    localparam int N  = WIDTH * LIMBS;
    localparam int IW = $clog2(LIMBS);
    localparam logic [IW-1:0] LAST = IW'(LIMBS - 1);

    state_t         state;
    logic [N-1:0]   a_reg;
    logic [N-1:0]   b_reg;      // already conditionally inverted for subtract
    logic           carry;
    logic [IW-1:0]  idx;

    logic [WIDTH-1:0] a_limb;
    logic [WIDTH-1:0] b_limb;
    logic [WIDTH-1:0] limb_sum;
    logic             limb_cout;
    logic             limb_cmsb;

    assign a_limb = a_reg[idx*WIDTH +: WIDTH];
    assign b_limb = b_reg[idx*WIDTH +: WIDTH];

    kgp_adder_cin #(.WIDTH(WIDTH)) u_adder (
        .a    (a_limb),
        .b    (b_limb),
        .cin  (carry),
        .sum  (limb_sum),
        .cout (limb_cout),
        .cmsb (limb_cmsb)
    );

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            carry     <= 1'b0;
            idx       <= '0;
            out_sum   <= '0;
            out_cout  <= 1'b0;
            out_ovf   <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg   <= in_a;
                        b_reg   <= in_b ^ {N{in_sub}};
                        carry   <= in_sub;   // +1 completes the two's complement of B
                        idx     <= '0;
                        out_sum <= '0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    out_sum[idx*WIDTH +: WIDTH] <= limb_sum;
                    carry <= limb_cout;
                    if (idx == LAST) begin
                        out_cout  <= limb_cout;
                        // Carry into the MSB differing from carry out is the
                        // same condition as equal operand signs with a
                        // different result sign.
                        out_ovf   <= limb_cmsb ^ limb_cout;
                        out_valid <= 1'b1;
                        idx       <= '0;
                        state     <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
